// File: rtl/clint_timer.sv
// Machine timer/software interrupt block: mtime, mtimecmp and msip on a slave data bus.
// Each request is acked one cycle after acceptance; a new request is only taken while no ack is outstanding.
module clint_timer #(
  parameter int unsigned TICK_DIV     = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        xint_mtip_o,
  output logic        xint_msip_o
);

  localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic {IDLE, ACK} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q;
  logic [63:0]   mtime_q, mtimecmp_q;
  logic          msip_q, mtip_q;
  logic [31:0]   rdata_q;

  logic          req, wr, tick;
  logic [2:0]    word;
  logic [31:0]   rd_mux;
  logic [63:0]   mtime_inc, mtime_d, mtimecmp_d;
  logic          msip_d;
  logic          unused_addr;

  assign unused_addr = ^addr_i[1:0];
  assign word        = addr_i[4:2];
  assign tick        = (presc_q == PRESC_MAX);
  assign mtime_inc   = tick ? mtime_q + 64'd1 : mtime_q;
  assign wr          = req & we_i;

  function automatic logic [31:0] merge(input logic [31:0] old_val,
                                        input logic [31:0] wdat,
                                        input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = wdat[8*b +: 8];
    end
    return r;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cyc_i && stb_i) begin
          req     = 1'b1;
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Unwritten mtime bytes follow the incremented value so a tick on the write edge is not lost.
  always_comb begin
    mtime_d    = mtime_inc;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wr) begin
      case (word)
        3'd0: if (sel_i[0]) msip_d = dat_i[0];
        3'd2: mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0],  dat_i, sel_i);
        3'd3: mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], dat_i, sel_i);
        3'd4: mtime_d[31:0]     = merge(mtime_inc[31:0],   dat_i, sel_i);
        3'd5: mtime_d[63:32]    = merge(mtime_inc[63:32],  dat_i, sel_i);
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (word)
      3'd0:    rd_mux = {31'b0, msip_q};
      3'd2:    rd_mux = mtimecmp_q[31:0];
      3'd3:    rd_mux = mtimecmp_q[63:32];
      3'd4:    rd_mux = mtime_q[31:0];
      3'd5:    rd_mux = mtime_q[63:32];
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= MTIMECMP_RST;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      presc_q    <= tick ? '0 : presc_q + PW'(1);
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      mtip_q     <= (mtime_q >= mtimecmp_q);
      rdata_q    <= (req && !we_i) ? rd_mux : '0;
    end
  end

  assign ack_o       = (state_q == ACK);
  assign dat_o       = rdata_q;
  assign xint_mtip_o = mtip_q;
  assign xint_msip_o = msip_q;

endmodule
